// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 4-stage pipeline.
// Load-use, branch flush, multi-cycle MUL occupancy, stall counter.
module pipeline_hazard_ctrl #(
  parameter logic [3:0] LOAD_OP    = 4'd8,
  parameter logic [3:0] MUL_OP     = 4'd10,
  parameter int         MUL_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] id_opcode,
  input  logic [3:0] id_src_a,
  input  logic [3:0] id_src_b,
  input  logic [3:0] ex_opcode,
  input  logic [3:0] ex_dest,
  input  logic       branch_taken,
  input  logic       stats_clr,
  output logic       hazard,
  output logic       idex_bubble,
  output logic       ex_hold,
  output logic       ifid_flush,
  output logic       busy,
  output logic [7:0] stall_cycles
);

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } state_e;

  // A single-cycle MUL never needs the busy window.
  localparam bit         MulMulti  = (MUL_CYCLES >= 2);
  localparam logic [3:0] McntInit  = 4'(MUL_CYCLES - 2);

  state_e     state_q, state_d;
  logic [3:0] mcnt_q, mcnt_d;
  logic [7:0] stall_q, stall_d;

  logic load_use;
  logic mul_issue;
  logic hz_c, bub_c, hold_c, fl_c, busy_c;

  // Consumer in ID reads a register a load in EX has not yet written.
  always_comb begin
    load_use = (ex_opcode == LOAD_OP) &&
               (ex_dest != 4'd0) &&
               (id_opcode != 4'd0) &&
               ((ex_dest == id_src_a) ||
                (ex_dest == id_src_b));
    mul_issue = MulMulti && (id_opcode == MUL_OP);
  end

  // Next-state and raw control decode, priority ordered in RUN.
  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    hz_c    = 1'b0;
    bub_c   = 1'b0;
    hold_c  = 1'b0;
    fl_c    = 1'b0;
    busy_c  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (branch_taken) begin
          fl_c  = 1'b1;
          bub_c = 1'b1;
        end else if (load_use) begin
          hz_c  = 1'b1;
          bub_c = 1'b1;
        end else if (mul_issue) begin
          state_d = MUL_BUSY;
          mcnt_d  = McntInit;
        end
      end
      MUL_BUSY: begin
        hz_c   = 1'b1;
        hold_c = 1'b1;
        busy_c = 1'b1;
        if (mcnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          mcnt_d = mcnt_q - 4'd1;
        end
      end
      default: begin
        state_d = RUN;
        mcnt_d  = 4'd0;
      end
    endcase
  end

  // Controls are forced quiet while reset is held.
  always_comb begin
    hazard      = hz_c   & ~reset;
    idex_bubble = bub_c  & ~reset;
    ex_hold     = hold_c & ~reset;
    ifid_flush  = fl_c   & ~reset;
    busy        = busy_c & ~reset;
  end

  // Saturating stall counter; clear beats increment.
  always_comb begin
    stall_d = stall_q;
    if (stats_clr) begin
      stall_d = 8'd0;
    end else if (hazard && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  // State, MUL countdown and stall counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      mcnt_q  <= 4'd0;
      stall_q <= 8'd0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl.
// MUL_CYCLES=3 main DUT plus a MUL_CYCLES=5 DUT for reset-mid-MUL.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_opcode, id_src_a, id_src_b;
  logic [3:0] ex_opcode, ex_dest;
  logic       branch_taken, stats_clr;

  logic       hazard, idex_bubble, ex_hold, ifid_flush, busy;
  logic [7:0] stall_cycles;
  logic       hazard5, idex_bubble5, ex_hold5, ifid_flush5, busy5;
  logic [7:0] stall_cycles5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .id_opcode(id_opcode), .id_src_a(id_src_a), .id_src_b(id_src_b),
    .ex_opcode(ex_opcode), .ex_dest(ex_dest),
    .branch_taken(branch_taken), .stats_clr(stats_clr),
    .hazard(hazard), .idex_bubble(idex_bubble), .ex_hold(ex_hold),
    .ifid_flush(ifid_flush), .busy(busy), .stall_cycles(stall_cycles)
  );

  pipeline_hazard_ctrl #(.MUL_CYCLES(5)) dut5 (
    .clk(clk), .reset(reset),
    .id_opcode(id_opcode), .id_src_a(id_src_a), .id_src_b(id_src_b),
    .ex_opcode(ex_opcode), .ex_dest(ex_dest),
    .branch_taken(branch_taken), .stats_clr(stats_clr),
    .hazard(hazard5), .idex_bubble(idex_bubble5), .ex_hold(ex_hold5),
    .ifid_flush(ifid_flush5), .busy(busy5), .stall_cycles(stall_cycles5)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Apply inputs just after the falling edge, settle 1 time unit.
  task automatic drive(input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] exo,
                       input logic [3:0] exd, input logic br,
                       input logic clr);
    @(negedge clk);
    id_opcode    = op;
    id_src_a     = a;
    id_src_b     = b;
    ex_opcode    = exo;
    ex_dest      = exd;
    branch_taken = br;
    stats_clr    = clr;
    #1;
  endtask

  task automatic idle();
    drive(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic outs(input string tag, input int hz, input int bb,
                      input int eh, input int fl, input int bs);
    chk({tag, ".hazard"}, 32'(hazard), hz);
    chk({tag, ".bubble"}, 32'(idex_bubble), bb);
    chk({tag, ".ex_hold"}, 32'(ex_hold), eh);
    chk({tag, ".flush"}, 32'(ifid_flush), fl);
    chk({tag, ".busy"}, 32'(busy), bs);
  endtask

  initial begin
    // Reset with a live load-use + branch pattern on the inputs.
    reset        = 1'b0;
    id_opcode    = 4'd3;
    id_src_a     = 4'd5;
    id_src_b     = 4'd5;
    ex_opcode    = 4'd8;
    ex_dest      = 4'd5;
    branch_taken = 1'b1;
    stats_clr    = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    outs("rst", 0, 0, 0, 0, 0);
    chk("rst.stall", 32'(stall_cycles), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      outs("idle", 0, 0, 0, 0, 0);
    end
    chk("idle.stall", 32'(stall_cycles), 0);

    // Load-use on src_b.
    drive(4'd3, 4'd1, 4'd5, 4'd8, 4'd5, 1'b0, 1'b0);
    outs("lu", 1, 1, 0, 0, 0);
    drive(4'd3, 4'd1, 4'd5, 4'd0, 4'd5, 1'b0, 1'b0);
    outs("lu_drop", 0, 0, 0, 0, 0);
    chk("lu.stall", 32'(stall_cycles), 1);
    // Destination r0 never matches.
    drive(4'd3, 4'd0, 4'd0, 4'd8, 4'd0, 1'b0, 1'b0);
    outs("lu_r0", 0, 0, 0, 0, 0);
    // NOP consumer never matches; load-use on src_a.
    drive(4'd0, 4'd6, 4'd6, 4'd8, 4'd6, 1'b0, 1'b0);
    outs("lu_nop", 0, 0, 0, 0, 0);
    drive(4'd4, 4'd6, 4'd2, 4'd8, 4'd6, 1'b0, 1'b0);
    outs("lu_a", 1, 1, 0, 0, 0);
    drive(4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    chk("pre_clr.stall", 32'(stall_cycles), 2);
    idle();
    chk("clr.stall", 32'(stall_cycles), 0);

    // Single MUL at cycle t.
    drive(4'd10, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    outs("mul_t", 0, 0, 0, 0, 0);
    drive(4'd3, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    outs("mul_t1", 1, 0, 1, 0, 1);
    drive(4'd3, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    outs("mul_t2", 1, 0, 1, 0, 1);
    drive(4'd3, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b1);
    outs("mul_t3", 0, 0, 0, 0, 0);
    chk("mul.stall", 32'(stall_cycles), 2);

    // Back-to-back MULs: second sits in ID during first window.
    drive(4'd10, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    outs("b2b_t", 0, 0, 0, 0, 0);
    drive(4'd10, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    outs("b2b_t1", 1, 0, 1, 0, 1);
    drive(4'd10, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    outs("b2b_t2", 1, 0, 1, 0, 1);
    drive(4'd10, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    outs("b2b_t3", 0, 0, 0, 0, 0);
    drive(4'd3, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    outs("b2b_t4", 1, 0, 1, 0, 1);
    drive(4'd3, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    outs("b2b_t5", 1, 0, 1, 0, 1);
    drive(4'd3, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    outs("b2b_t6", 0, 0, 0, 0, 0);
    chk("b2b.stall", 32'(stall_cycles), 4);

    // Branch beats load-use.
    drive(4'd3, 4'd5, 4'd1, 4'd8, 4'd5, 1'b1, 1'b0);
    outs("br_lu", 0, 1, 0, 1, 0);
    // Branch ignored while busy.
    drive(4'd10, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    drive(4'd3, 4'd1, 4'd2, 4'd8, 4'd1, 1'b1, 1'b0);
    outs("br_busy", 1, 0, 1, 0, 1);
    drive(4'd3, 4'd1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0);
    outs("br_busy2", 1, 0, 1, 0, 1);
    drive(4'd3, 4'd1, 4'd2, 4'd0, 4'd0, 1'b1, 1'b0);
    outs("br_run", 0, 1, 0, 1, 0);
    idle();

    // Reset in the middle of a 5-cycle MUL.
    drive(4'd10, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("m5_t.busy", 32'(busy5), 0);
    drive(4'd3, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("m5_t1.busy", 32'(busy5), 1);
    chk("m5_t1.hazard", 32'(hazard5), 1);
    #1;
    reset = 1'b1;
    #1;
    chk("m5_rst.busy", 32'(busy5), 0);
    chk("m5_rst.hazard", 32'(hazard5), 0);
    chk("m5_rst.ex_hold", 32'(ex_hold5), 0);
    chk("m5_rst.stall", 32'(stall_cycles5), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(4'd3, 4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0);
      chk("m5_post.hazard", 32'(hazard5), 0);
      chk("m5_post.busy", 32'(busy5), 0);
    end

    // Saturation, then clear while a hazard is active.
    drive(4'd3, 4'd7, 4'd7, 4'd8, 4'd7, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
    end
    #1;
    chk("sat.hazard", 32'(hazard), 1);
    chk("sat.stall", 32'(stall_cycles), 255);
    drive(4'd3, 4'd7, 4'd7, 4'd8, 4'd7, 1'b0, 1'b0);
    chk("sat_hold.stall", 32'(stall_cycles), 255);
    drive(4'd3, 4'd7, 4'd7, 4'd8, 4'd7, 1'b0, 1'b1);
    chk("clr_hz.hazard", 32'(hazard), 1);
    drive(4'd3, 4'd7, 4'd7, 4'd8, 4'd7, 1'b0, 1'b0);
    chk("clr_hz.stall", 32'(stall_cycles), 0);
    drive(4'd3, 4'd7, 4'd7, 4'd8, 4'd7, 1'b0, 1'b0);
    chk("clr_inc.stall", 32'(stall_cycles), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
